// File: rtl/core_if_pc_ras_pkg.sv
// Shared constants and types for the IF-stage PC generator.
// Imported by the PC generator top and its return-address stack.
package core_if_pc_ras_pkg;

  localparam int CORE_PC_WIDTH = 32;
  localparam logic [31:0] CORE_PC_RESET_VALUE = 32'h8000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BJ,
    SEL_RAS,
    SEL_FLUSH
  } pc_sel_e;

endpackage

// File: rtl/core_if_pc_ras_if.sv
// Fetch-request handshake between the PC generator and instruction fetch.
// The PC generator is the master; fetch is the slave.
interface core_if_pc_ras_if #(
  parameter int PC_WIDTH = 32
);

  logic                pc_valid;
  logic                pc_ready;
  logic [PC_WIDTH-1:0] pc_current;

  modport master (
    output pc_valid,
    output pc_current,
    input  pc_ready
  );

  modport slave (
    input  pc_valid,
    input  pc_current,
    output pc_ready
  );

endinterface

// File: rtl/core_if_ras.sv
// Circular return-address stack: push, pop, in-place replace, clear.
// Overflow silently overwrites the oldest entry.
module core_if_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  top_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;
  logic [PW-1:0] wr_idx;

  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    if (clear_i) begin
      top_d = '0;
      cnt_d = '0;
    end else if (push_i && pop_i) begin
      // call+ret: target already read from top, swap in the new return
      wr_en = 1'b1;
    end else if (push_i) begin
      top_d  = top_q + PW'(1);
      wr_idx = top_q + PW'(1);
      wr_en  = 1'b1;
      if (cnt_q != CW'(DEPTH))
        cnt_d = cnt_q + CW'(1);
    end else if (pop_i) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_idx] <= data_i;
  end

  assign top_o   = mem_q[top_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/core_if_pc_ras.sv
// IF-stage PC generator: flush > RAS pop > offset branch > sequential.
// Holds pc_current under fetch back-pressure.
module core_if_pc_ras
  import core_if_pc_ras_pkg::*;
#(
  parameter int                  PC_WIDTH    = CORE_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(CORE_PC_RESET_VALUE),
  parameter int                  FETCH_BYTES = 4,
  parameter int                  RAS_DEPTH   = 4,
  parameter int                  CW          = $clog2(RAS_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  core_if_pc_ras_if.master    fetch,
  input  logic                pipe_flush_req,
  input  logic [PC_WIDTH-1:0] exu_pipe_flush_pc,
  input  logic                ras_clear,
  input  logic                bj_predict,
  input  logic [PC_WIDTH-1:0] bj_offset,
  input  logic                call_predict,
  input  logic                ret_predict,
  output logic                branch_jump_predict,
  output logic                ras_miss,
  output logic [CW-1:0]       ras_count
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                valid_q;
  logic                acc;
  logic                pc_en;
  logic                ras_hit;
  logic                ras_en;
  logic [PC_WIDTH-1:0] ras_top;
  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] pc_bj;
  pc_sel_e             sel;

  assign acc     = valid_q & fetch.pc_ready;
  assign pc_en   = acc | pipe_flush_req;
  assign ras_hit = ret_predict & (ras_count != '0);
  assign ras_en  = acc & ~pipe_flush_req;
  assign pc_seq  = pc_q + PC_WIDTH'(FETCH_BYTES);
  assign pc_bj   = pc_q + bj_offset;

  always_comb begin
    sel = SEL_SEQ;
    if (pipe_flush_req)  sel = SEL_FLUSH;
    else if (ras_hit)    sel = SEL_RAS;
    else if (bj_predict) sel = SEL_BJ;
  end

  always_comb begin
    pc_d = pc_seq;
    unique case (sel)
      SEL_FLUSH: pc_d = exu_pipe_flush_pc;
      SEL_RAS:   pc_d = ras_top;
      SEL_BJ:    pc_d = pc_bj;
      SEL_SEQ:   pc_d = pc_seq;
    endcase
  end

  assign branch_jump_predict = (sel == SEL_RAS) | (sel == SEL_BJ);
  assign ras_miss = ras_en & ret_predict & (ras_count == '0);

  // enable flop with async-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pc_q <= RESET_PC;
    else if (pc_en) pc_q <= pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= 1'b1;
  end

  assign fetch.pc_valid   = valid_q;
  assign fetch.pc_current = pc_q;

  core_if_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_WIDTH),
    .CW    (CW)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ras_en & call_predict),
    .pop_i   (ras_en & ras_hit),
    .clear_i (pipe_flush_req & ras_clear),
    .data_i  (pc_seq),
    .top_o   (ras_top),
    .count_o (ras_count)
  );

endmodule
